// File: rtl/cnt_sched.sv
// Round-robin command scheduler that sequences the latch/decrement/halve counter for two requesters.
// Optional abort support (abort / done_aborted ports) is compiled in when CNT_SCHED_ABORT_EN is defined.
module cnt_sched #(
    parameter int DW = 8,
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic          a_op,
    input  logic [DW-1:0] a_val,
    input  logic [SW-1:0] a_steps,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic          b_op,
    input  logic [DW-1:0] b_val,
    input  logic [SW-1:0] b_steps,
    output logic          busy,
    output logic          done,
    output logic          done_id,
    output logic [DW-1:0] result,
    output logic [DW-1:0] cnt_in,
    output logic          cnt_latch,
    output logic          cnt_dec,
    output logic          cnt_div,
    input  logic [DW-1:0] cnt_count
`ifdef CNT_SCHED_ABORT_EN
    ,
    input  logic          abort,
    output logic          done_aborted
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic          OP_HALVE = 1'b1;
    localparam logic [SW-1:0] STEP_ONE = {{(SW-1){1'b0}}, 1'b1};

    state_t        state_r;
    state_t        state_next_s;
    logic          last_r;
    logic          op_r;
    logic          id_r;
    logic [SW-1:0] steps_rem_r;
    logic [DW-1:0] cnt_in_r;
    logic          busy_r;
    logic          done_r;
    logic          done_id_r;
    logic [DW-1:0] result_r;

    logic          grant_a_s;
    logic          grant_b_s;
    logic          accept_s;
    logic          sel_id_s;
    logic          sel_op_s;
    logic [DW-1:0] sel_val_s;
    logic [SW-1:0] sel_steps_s;
    logic          latch_s;
    logic          dec_s;
    logic          div_s;
    logic          abort_s;

`ifdef CNT_SCHED_ABORT_EN
    logic          done_aborted_r;

    assign abort_s      = abort;
    assign done_aborted = done_aborted_r;
`else
    assign abort_s      = 1'b0;
`endif

    // Round-robin grant: on a tie the requester not served last wins.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (!rst && (state_r == ST_IDLE)) begin
            if (a_valid && b_valid) begin
                grant_a_s = last_r;
                grant_b_s = !last_r;
            end else begin
                grant_a_s = a_valid;
                grant_b_s = b_valid;
            end
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    assign accept_s = grant_a_s | grant_b_s;

    // Payload of the granted requester.
    always_comb begin
        sel_id_s    = 1'b0;
        sel_op_s    = a_op;
        sel_val_s   = a_val;
        sel_steps_s = a_steps;
        if (grant_b_s) begin
            sel_id_s    = 1'b1;
            sel_op_s    = b_op;
            sel_val_s   = b_val;
            sel_steps_s = b_steps;
        end else begin
            sel_id_s    = 1'b0;
        end
    end

    // Next-state and counter strobes; an abort suppresses the strobe of its cycle.
    always_comb begin
        state_next_s = state_r;
        latch_s      = 1'b0;
        dec_s        = 1'b0;
        div_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (abort_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    latch_s      = 1'b1;
                    state_next_s = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort_s) begin
                    state_next_s = ST_DONE;
                end else if (op_r == OP_HALVE) begin
                    if (steps_rem_r != '0) begin
                        div_s = 1'b1;
                    end else begin
                        state_next_s = ST_DONE;
                    end
                end else begin
                    // Never decrement at zero so the counter's sticky zero flag stays clear.
                    if (cnt_count != '0) begin
                        dec_s = 1'b1;
                    end else begin
                        state_next_s = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, captured command and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            last_r      <= 1'b1;
            op_r        <= 1'b0;
            id_r        <= 1'b0;
            steps_rem_r <= '0;
            cnt_in_r    <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            done_id_r   <= 1'b0;
            result_r    <= '0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != ST_IDLE);
            done_r  <= (state_next_s == ST_DONE);
            if (accept_s) begin
                op_r        <= sel_op_s;
                id_r        <= sel_id_s;
                last_r      <= sel_id_s;
                steps_rem_r <= sel_steps_s;
                cnt_in_r    <= sel_val_s;
            end else if (div_s) begin
                steps_rem_r <= steps_rem_r - STEP_ONE;
            end
            // No strobe fires in the exit cycle, so this count equals the one seen during DONE.
            if (state_next_s == ST_DONE) begin
                done_id_r <= id_r;
                result_r  <= cnt_count;
            end
        end
    end

`ifdef CNT_SCHED_ABORT_EN
    // Flags completions caused by abort rather than by the natural end of RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_aborted_r <= 1'b0;
        end else if (state_next_s == ST_DONE) begin
            done_aborted_r <= abort_s;
        end else begin
            done_aborted_r <= done_aborted_r;
        end
    end
`endif

    assign a_ready   = grant_a_s;
    assign b_ready   = grant_b_s;
    assign busy      = busy_r;
    assign done      = done_r;
    assign done_id   = done_id_r;
    assign result    = result_r;
    assign cnt_in    = cnt_in_r;
    assign cnt_latch = latch_s;
    assign cnt_dec   = dec_s;
    assign cnt_div   = div_s;

endmodule
